mem_stage_ctrl: RTL and testbench

//  Memory-stage request initiator. Consumes EX/MEM control (read/write/LL/SC/halt) and drives the dcache request.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/mem_stage_ctrl_link_reg.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the memory stage controller and its link register.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, ACCESS, HALTED} mem_state_t;

    typedef enum logic [1:0] {LW, SW, LL, SC} mem_kind_t;

    // A simultaneous read and write request is treated as a read.
    function automatic mem_kind_t decode_kind(input logic ren, input logic ll, input logic sc);
        if (ren)
            return ll ? LL : LW;
        else
            return sc ? SC : SW;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_link_reg.sv
// Load-linked reservation: one address plus a valid bit, with an address match against the
// store-conditional that is currently presented.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set,
    input  logic  clr,
    input  word_t set_addr,
    input  word_t chk_addr,
    output logic  link_valid,
    output word_t link_addr,
    output logic  hit
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            link_valid <= 1'b1;
            link_addr  <= set_addr;
        end else if (clr) begin
            link_valid <= 1'b0;
        end
    end

    assign hit = link_valid && (link_addr == chk_addr);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage request initiator: issues one dcache access at a time from EX/MEM control,
// stalls upstream until dhit, and handles LL/SC reservation, halt and access timeout.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  memRen_in,
    input  logic  memWen_in,
    input  logic  ll_in,
    input  logic  sc_in,
    input  word_t addr_in,
    input  word_t store_in,
    input  logic  halt_in,
    input  logic  flush,
    input  logic  dhit,
    input  word_t dload,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    output word_t dmemload_out,
    output logic  mem_stall,
    output logic  halt_out,
    output logic  mem_err
);

    mem_state_t       state, state_n;
    mem_kind_t        kind, kind_in;
    word_t            addr_q, store_q, load_q;
    logic             ren_q, wen_q, halt_pend, err_q;
    logic [CNT_W-1:0] wait_cnt;

    logic  sc_ok, sc_fail, op, timeout;
    logic  link_set, link_clr, link_valid;
    word_t link_addr;

    link_reg u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (link_set),
        .clr        (link_clr),
        .set_addr   (addr_q),
        .chk_addr   (addr_in),
        .link_valid (link_valid),
        .link_addr  (link_addr),
        .hit        (sc_ok)
    );

    assign kind_in = decode_kind(memRen_in, ll_in, sc_in);
    assign sc_fail = memWen_in && !memRen_in && sc_in && !sc_ok && !flush;
    assign op      = (memRen_in || memWen_in) && !flush && !sc_fail;
    assign timeout = (state == ACCESS) && !dhit && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign dREN     = ren_q;
    assign dWEN     = wen_q;
    assign daddr    = addr_q;
    assign dstore   = store_q;
    assign halt_out = (state == HALTED);
    assign mem_err  = err_q;

    always_comb begin
        state_n      = state;
        mem_stall    = 1'b0;
        dmemload_out = load_q;
        link_set     = 1'b0;
        link_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (op) begin
                    mem_stall = 1'b1;
                    state_n   = ACCESS;
                end else if (halt_in && !flush) begin
                    state_n = HALTED;
                end
                if (sc_fail)
                    dmemload_out = '0;
            end
            ACCESS: begin
                mem_stall = !dhit;
                if (dhit) begin
                    dmemload_out = (kind == SC) ? 32'd1 : dload;
                    state_n      = (halt_pend || halt_in) ? HALTED : IDLE;
                    link_set     = (kind == LL);
                    // A completed SC always consumed the reservation; a plain store only kills a matching one.
                    link_clr     = (kind == SC) || (kind == SW && link_addr == addr_q);
                end
            end
            HALTED: ;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            kind      <= LW;
            addr_q    <= '0;
            store_q   <= '0;
            load_q    <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            halt_pend <= 1'b0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (op) begin
                        kind      <= kind_in;
                        addr_q    <= addr_in;
                        store_q   <= store_in;
                        ren_q     <= (kind_in == LW) || (kind_in == LL);
                        wen_q     <= (kind_in == SW) || (kind_in == SC);
                        halt_pend <= halt_in;
                        wait_cnt  <= '0;
                    end else if (sc_fail) begin
                        load_q <= '0;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        ren_q     <= 1'b0;
                        wen_q     <= 1'b0;
                        halt_pend <= 1'b0;
                        load_q    <= dmemload_out;
                    end else begin
                        // Saturate so a hung access never wraps back to a timeout compare.
                        if (wait_cnt != '1)
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        if (timeout)
                            err_q <= 1'b1;
                        if (halt_in)
                            halt_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, LL/SC, flush, halt, timeout and async reset.
module tb_mem_stage_ctrl;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  memRen_in, memWen_in, ll_in, sc_in, halt_in, flush, dhit;
    word_t addr_in, store_in, dload;
    logic  dREN, dWEN, mem_stall, halt_out, mem_err;
    word_t daddr, dstore, dmemload_out;

    int passed = 0;
    int total  = 0;

    mem_stage_ctrl dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .memRen_in    (memRen_in),
        .memWen_in    (memWen_in),
        .ll_in        (ll_in),
        .sc_in        (sc_in),
        .addr_in      (addr_in),
        .store_in     (store_in),
        .halt_in      (halt_in),
        .flush        (flush),
        .dhit         (dhit),
        .dload        (dload),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .daddr        (daddr),
        .dstore       (dstore),
        .dmemload_out (dmemload_out),
        .mem_stall    (mem_stall),
        .halt_out     (halt_out),
        .mem_err      (mem_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic clear_inputs();
        memRen_in = 0; memWen_in = 0; ll_in = 0; sc_in = 0;
        halt_in = 0; flush = 0; dhit = 0;
        addr_in = '0; store_in = '0; dload = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents one op at cycle 0 and raises dhit at cycle hit_cyc; gathers what the bus did.
    task automatic do_access(input logic ren, input logic wen, input logic ll, input logic sc,
                             input word_t addr, input word_t data, input int hit_cyc, input word_t dl,
                             output int ren_cnt, output int wen_cnt, output int occ,
                             output logic stall0, output word_t res0, output word_t res,
                             output word_t addr_seen, output word_t data_seen);
        ren_cnt = 0; wen_cnt = 0; occ = 0; stall0 = 0;
        res0 = '0; res = '0; addr_seen = '0; data_seen = '0;
        memRen_in = ren; memWen_in = wen; ll_in = ll; sc_in = sc;
        addr_in = addr; store_in = data;
        for (int c = 0; c < hit_cyc + 3; c++) begin
            if (c > hit_cyc) clear_inputs();
            dhit  = (c == hit_cyc);
            dload = (c == hit_cyc) ? dl : 32'hA5A5_A5A5;
            @(negedge CLK);
            if (dREN) ren_cnt++;
            if (dWEN) wen_cnt++;
            if (mem_stall || dREN || dWEN) occ++;
            if (c == 0) begin
                stall0 = mem_stall;
                res0   = dmemload_out;
            end
            if (c == hit_cyc) begin
                res       = dmemload_out;
                addr_seen = daddr;
                data_seen = dstore;
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++;
        if ({dREN, dWEN, mem_stall, halt_out, mem_err} !== 5'b0) $display("FAIL reset_ctrl: got %b required 00000", {dREN, dWEN, mem_stall, halt_out, mem_err});
        else passed++;
        total++;
        if ({daddr, dstore, dmemload_out} !== 96'h0) $display("FAIL reset_data: got %h %h %h required 0 0 0", daddr, dstore, dmemload_out);
        else passed++;
        nRST = 1;
        tick();
    endtask

    task automatic test_load();
        int rc, wc, oc; logic s0; word_t r0, r, a, d;
        do_access(1, 0, 0, 0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, rc, wc, oc, s0, r0, r, a, d);
        total++;
        if (rc !== 3 || wc !== 0) $display("FAIL lw_req_cycles: got dREN=%0d dWEN=%0d required 3 0", rc, wc);
        else passed++;
        total++;
        if (oc !== 4 || s0 !== 1'b1) $display("FAIL lw_stall: got occupancy=%0d stall0=%b required 4 1", oc, s0);
        else passed++;
        total++;
        if (r !== 32'hDEAD_BEEF || a !== 32'h40) $display("FAIL lw_data: got %h @%h required deadbeef @40", r, a);
        else passed++;
        @(negedge CLK);
        total++;
        if (dmemload_out !== 32'hDEAD_BEEF || dREN !== 1'b0) $display("FAIL lw_hold: got %h dREN=%b required deadbeef 0", dmemload_out, dREN);
        else passed++;
        tick();
    endtask

    task automatic test_store();
        int rc, wc, oc; logic s0; word_t r0, r, a, d;
        do_access(0, 1, 0, 0, 32'h80, 32'h1234, 1, 32'h0, rc, wc, oc, s0, r0, r, a, d);
        total++;
        if (wc !== 1 || rc !== 0 || oc !== 2) $display("FAIL sw_cycles: got dWEN=%0d dREN=%0d occ=%0d required 1 0 2", wc, rc, oc);
        else passed++;
        total++;
        if (a !== 32'h80 || d !== 32'h1234) $display("FAIL sw_bus: got addr=%h data=%h required 80 1234", a, d);
        else passed++;
    endtask

    task automatic test_ll_sc();
        int rc, wc, oc; logic s0; word_t r0, r, a, d;
        do_access(1, 0, 1, 0, 32'h100, 32'h0, 2, 32'h55, rc, wc, oc, s0, r0, r, a, d);
        total++;
        if (r !== 32'h55 || rc !== 2) $display("FAIL ll_load: got %h dREN=%0d required 55 2", r, rc);
        else passed++;
        do_access(0, 1, 0, 1, 32'h100, 32'h7, 1, 32'h0, rc, wc, oc, s0, r0, r, a, d);
        total++;
        if (wc !== 1 || r !== 32'h1 || d !== 32'h7) $display("FAIL sc_ok: got dWEN=%0d result=%h data=%h required 1 1 7", wc, r, d);
        else passed++;
        do_access(0, 1, 0, 1, 32'h100, 32'h7, 1, 32'h0, rc, wc, oc, s0, r0, r, a, d);
        total++;
        if (wc !== 0 || oc !== 0 || s0 !== 1'b0 || r0 !== 32'h0) $display("FAIL sc_repeat: got dWEN=%0d occ=%0d stall=%b result=%h required 0 0 0 0", wc, oc, s0, r0);
        else passed++;
    endtask

    task automatic test_sc_after_store();
        int rc, wc, oc; logic s0; word_t r0, r, a, d;
        do_access(1, 0, 1, 0, 32'h100, 32'h0, 1, 32'h11, rc, wc, oc, s0, r0, r, a, d);
        do_access(0, 1, 0, 0, 32'h100, 32'h22, 1, 32'h99, rc, wc, oc, s0, r0, r, a, d);
        do_access(0, 1, 0, 1, 32'h100, 32'h33, 1, 32'h0, rc, wc, oc, s0, r0, r, a, d);
        total++;
        if (wc !== 0 || oc !== 0 || r0 !== 32'h0) $display("FAIL sc_after_sw: got dWEN=%0d occ=%0d result=%h required 0 0 0", wc, oc, r0);
        else passed++;
        do_access(1, 0, 1, 0, 32'h200, 32'h0, 1, 32'h11, rc, wc, oc, s0, r0, r, a, d);
        do_access(0, 1, 0, 0, 32'h204, 32'h22, 1, 32'h99, rc, wc, oc, s0, r0, r, a, d);
        do_access(0, 1, 0, 1, 32'h200, 32'h33, 1, 32'h0, rc, wc, oc, s0, r0, r, a, d);
        total++;
        if (wc !== 1 || r !== 32'h1) $display("FAIL sc_other_addr: got dWEN=%0d result=%h required 1 1", wc, r);
        else passed++;
    endtask

    task automatic test_flush();
        memRen_in = 1; flush = 1; addr_in = 32'h500;
        @(negedge CLK);
        total++;
        if (mem_stall !== 1'b0) $display("FAIL flush_stall: got %b required 0", mem_stall);
        else passed++;
        tick();
        @(negedge CLK);
        total++;
        if (dREN !== 1'b0) $display("FAIL flush_req: got dREN=%b required 0", dREN);
        else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        memRen_in = 1; addr_in = 32'h300;
        tick();
        for (int k = 1; k <= 257; k++) begin
            @(negedge CLK);
            if (k == 256) begin
                total++;
                if (mem_err !== 1'b0) $display("FAIL timeout_early: got %b required 0", mem_err);
                else passed++;
            end
            if (k == 257) begin
                total++;
                if (mem_err !== 1'b1 || dREN !== 1'b1) $display("FAIL timeout_set: got err=%b dREN=%b required 1 1", mem_err, dREN);
                else passed++;
            end
            tick();
        end
        clear_inputs();
        #2;
        nRST = 0;
        #1;
        total++;
        if ({dREN, dWEN, mem_stall, halt_out, mem_err} !== 5'b0 || daddr !== 32'h0) $display("FAIL async_reset: got %b addr=%h required 00000 0", {dREN, dWEN, mem_stall, halt_out, mem_err}, daddr);
        else passed++;
        #1;
        nRST = 1;
        tick();
    endtask

    task automatic test_halt_during_access();
        logic ho_ok, req_ok, st_ok;
        memRen_in = 1; addr_in = 32'h40;
        tick();
        halt_in = 1;
        @(negedge CLK);
        total++;
        if (dREN !== 1'b1 || halt_out !== 1'b0 || mem_stall !== 1'b1) $display("FAIL halt_pending: got dREN=%b halt=%b stall=%b required 1 0 1", dREN, halt_out, mem_stall);
        else passed++;
        tick();
        dhit = 1; dload = 32'h77;
        @(negedge CLK);
        total++;
        if (dmemload_out !== 32'h77 || halt_out !== 1'b0) $display("FAIL halt_lw_done: got %h halt=%b required 77 0", dmemload_out, halt_out);
        else passed++;
        tick();
        dhit = 0; halt_in = 0; memRen_in = 1; addr_in = 32'h44;
        ho_ok = 1; req_ok = 1; st_ok = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (halt_out !== 1'b1) ho_ok = 0;
            if (dREN !== 1'b0 || dWEN !== 1'b0) req_ok = 0;
            if (mem_stall !== 1'b0) st_ok = 0;
            tick();
        end
        total++;
        if (!ho_ok) $display("FAIL halt_sticky: got halt_out low in HALTED, required 1");
        else passed++;
        total++;
        if (!req_ok || !st_ok) $display("FAIL halt_quiet: got req_ok=%b stall_ok=%b required 1 1", req_ok, st_ok);
        else passed++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_ll_sc();
        test_sc_after_store();
        test_flush();
        test_timeout();
        test_halt_during_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
